cdb_arbiter: RTL

//  Shares the single common data bus (CDB) between the two result producers, ALU and LSB.

---
 rtl/cdb_arbiter_pkg.sv | 17 +
 rtl/cdb_result_fifo.sv | 67 ++++++
 rtl/cdb_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter.
// Widths, source encodings and the grant type.
package cdb_arbiter_pkg;

    localparam int CDB_ROB_IDX_W = 4;
    localparam int CDB_DATA_W    = 32;
    localparam int CDB_DEPTH     = 4;

    localparam logic CDB_SRC_ALU = 1'b0;
    localparam logic CDB_SRC_LSB = 1'b1;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSB = 1'b1
    } grant_e;

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-producer result queue feeding the CDB arbiter.
// A full queue still accepts a push when it is popped at the same edge.
module cdb_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full,
    output logic         push_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign head      = mem[rd_ptr];
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign push_drop = push && full && !do_pop;

    // Storage write; flushed or frozen cycles never write.
    always_ff @(posedge clk) begin
        if (!rst && !flush && en && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (en) begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB between ALU and LSB.
// Broadcasts one queued result per cycle from a registered output.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_IDX_W = CDB_ROB_IDX_W,
    parameter int DATA_W    = CDB_DATA_W,
    parameter int DEPTH     = CDB_DEPTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clr_in,
    input  logic                 alu_valid,
    input  logic [ROB_IDX_W-1:0] alu_rob_index,
    input  logic [DATA_W-1:0]    alu_result,
    output logic                 alu_full,
    input  logic                 lsb_valid,
    input  logic [ROB_IDX_W-1:0] lsb_rob_index,
    input  logic [DATA_W-1:0]    lsb_result,
    output logic                 lsb_full,
    output logic                 cdb_ready,
    output logic [ROB_IDX_W-1:0] cdb_rob_index,
    output logic [DATA_W-1:0]    cdb_result,
    output logic                 cdb_src,
    output logic                 overflow
);

    localparam int W = ROB_IDX_W + DATA_W;

    logic [W-1:0] alu_head;
    logic [W-1:0] lsb_head;
    logic         alu_empty;
    logic         lsb_empty;
    logic         alu_drop;
    logic         lsb_drop;
    logic         alu_pop;
    logic         lsb_pop;
    grant_e       last_grant;

    cdb_result_fifo #(
        .DEPTH(DEPTH),
        .W    (W)
    ) u_alu_fifo (
        .clk      (clk_in),
        .rst      (rst_in),
        .en       (rdy_in),
        .flush    (clr_in),
        .push     (alu_valid),
        .push_data({alu_rob_index, alu_result}),
        .pop      (alu_pop),
        .head     (alu_head),
        .empty    (alu_empty),
        .full     (alu_full),
        .push_drop(alu_drop)
    );

    cdb_result_fifo #(
        .DEPTH(DEPTH),
        .W    (W)
    ) u_lsb_fifo (
        .clk      (clk_in),
        .rst      (rst_in),
        .en       (rdy_in),
        .flush    (clr_in),
        .push     (lsb_valid),
        .push_data({lsb_rob_index, lsb_result}),
        .pop      (lsb_pop),
        .head     (lsb_head),
        .empty    (lsb_empty),
        .full     (lsb_full),
        .push_drop(lsb_drop)
    );

    // Pick a head: lone non-empty queue wins, ties go to the one not served last.
    always_comb begin
        alu_pop = 1'b0;
        lsb_pop = 1'b0;
        if (!alu_empty && !lsb_empty) begin
            if (last_grant == GRANT_ALU) begin
                lsb_pop = 1'b1;
            end else begin
                alu_pop = 1'b1;
            end
        end else if (!alu_empty) begin
            alu_pop = 1'b1;
        end else if (!lsb_empty) begin
            lsb_pop = 1'b1;
        end
    end

    // Broadcast register, grant history and sticky overflow.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cdb_ready     <= 1'b0;
            cdb_rob_index <= '0;
            cdb_result    <= '0;
            cdb_src       <= CDB_SRC_ALU;
            overflow      <= 1'b0;
            last_grant    <= GRANT_ALU;
        end else if (clr_in) begin
            cdb_ready  <= 1'b0;
            last_grant <= GRANT_ALU;
        end else if (rdy_in) begin
            cdb_ready <= alu_pop || lsb_pop;
            if (lsb_pop) begin
                {cdb_rob_index, cdb_result} <= lsb_head;
                cdb_src    <= CDB_SRC_LSB;
                last_grant <= GRANT_LSB;
            end else if (alu_pop) begin
                {cdb_rob_index, cdb_result} <= alu_head;
                cdb_src    <= CDB_SRC_ALU;
                last_grant <= GRANT_ALU;
            end
            if (alu_drop || lsb_drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
